// File: rtl/ap_mult_err_mon.sv
// rtl/ap_mult_err_mon.sv - sequential exact-vs-approximate multiplier error monitor
module ap_mult_err_mon #(
    parameter int DW    = 12,
    parameter int CNT_W = 16,
    parameter int SUM_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      muld,
    input  logic [DW-1:0]      mulr,
    input  logic [2*DW-1:0]    res_ap,
    input  logic               clr,
    output logic               out_valid,
    output logic [2*DW-1:0]    exact,
    output logic [2*DW-1:0]    err_abs,
    output logic               err_neg,
    output logic [CNT_W-1:0]   n_samples,
    output logic [CNT_W-1:0]   n_mismatch,
    output logic [2*DW-1:0]    err_max,
    output logic [SUM_W-1:0]   err_sum
);

    localparam int PW = 2 * DW;
    localparam int IW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, UPD} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      muld_q, muld_d;
    logic [DW-1:0]      mulr_q, mulr_d;
    logic [PW-1:0]      res_ap_q, res_ap_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      exact_q, exact_d;
    logic [PW-1:0]      err_abs_q, err_abs_d;
    logic               err_neg_q, err_neg_d;
    logic [CNT_W-1:0]   n_samples_q, n_samples_d;
    logic [CNT_W-1:0]   n_mismatch_q, n_mismatch_d;
    logic [PW-1:0]      err_max_q, err_max_d;
    logic [SUM_W-1:0]   err_sum_q, err_sum_d;

    // Signed difference of the captured approximate product against the exact one
    logic [PW:0]        diff;
    logic [PW:0]        diff_neg;
    logic [PW-1:0]      abs_w;
    logic [SUM_W:0]     sum_ext;

    // Error magnitude and saturating-sum helper for the UPD cycle
    always_comb begin
        diff     = {1'b0, res_ap_q} - {1'b0, acc_q};
        diff_neg = (~diff) + (PW+1)'(1);
        abs_w    = diff[PW] ? diff_neg[PW-1:0] : diff[PW-1:0];
        sum_ext  = {1'b0, err_sum_q} + (SUM_W+1)'(abs_w);
    end

    // Next-state logic: handshake capture, shift-add engine, result and statistics update
    always_comb begin
        state_d      = state_q;
        muld_d       = muld_q;
        mulr_d       = mulr_q;
        res_ap_d     = res_ap_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        out_valid_d  = 1'b0;
        exact_d      = exact_q;
        err_abs_d    = err_abs_q;
        err_neg_d    = err_neg_q;
        n_samples_d  = n_samples_q;
        n_mismatch_d = n_mismatch_q;
        err_max_d    = err_max_q;
        err_sum_d    = err_sum_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    muld_d   = muld;
                    mulr_d   = mulr;
                    res_ap_d = res_ap;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mulr_q[idx_q]) begin
                    acc_d = acc_q + (PW'(muld_q) << idx_q);
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(DW - 1)) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                exact_d     = acc_q;
                err_abs_d   = abs_w;
                err_neg_d   = diff[PW];
                out_valid_d = 1'b1;
                if (n_samples_q != '1) begin
                    n_samples_d = n_samples_q + CNT_W'(1);
                end
                if ((abs_w != '0) && (n_mismatch_q != '1)) begin
                    n_mismatch_d = n_mismatch_q + CNT_W'(1);
                end
                if (abs_w > err_max_q) begin
                    err_max_d = abs_w;
                end
                err_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing statistics wins over the UPD update; per-sample results are unaffected
        if (clr) begin
            n_samples_d  = '0;
            n_mismatch_d = '0;
            err_max_d    = '0;
            err_sum_d    = '0;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            muld_q       <= '0;
            mulr_q       <= '0;
            res_ap_q     <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            exact_q      <= '0;
            err_abs_q    <= '0;
            err_neg_q    <= 1'b0;
            n_samples_q  <= '0;
            n_mismatch_q <= '0;
            err_max_q    <= '0;
            err_sum_q    <= '0;
        end else begin
            state_q      <= state_d;
            muld_q       <= muld_d;
            mulr_q       <= mulr_d;
            res_ap_q     <= res_ap_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            exact_q      <= exact_d;
            err_abs_q    <= err_abs_d;
            err_neg_q    <= err_neg_d;
            n_samples_q  <= n_samples_d;
            n_mismatch_q <= n_mismatch_d;
            err_max_q    <= err_max_d;
            err_sum_q    <= err_sum_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign exact      = exact_q;
    assign err_abs    = err_abs_q;
    assign err_neg    = err_neg_q;
    assign n_samples  = n_samples_q;
    assign n_mismatch = n_mismatch_q;
    assign err_max    = err_max_q;
    assign err_sum    = err_sum_q;

endmodule
